pong_arena: RTL

//  Parametrised two-player pong object engine: two paddles, one round ball, top/bottom walls.

---
 rtl/pong_arena_pkg.sv | 26 ++
 rtl/pong_arena_if.sv | 25 ++
 rtl/pong_arena_paddle.sv | 50 +++++
 rtl/pong_arena.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pong_arena_pkg.sv
// Shared constants and the round-ball bitmap for the pong object engine.
package pong_arena_pkg;

    localparam int unsigned DEF_MAX_X = 640;
    localparam int unsigned DEF_MAX_Y = 480;
    localparam int unsigned BALL_SIZE = 8;

    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_BARR = 3'b101;
    localparam rgb_t RGB_BARL = 3'b010;
    localparam rgb_t RGB_BALL = 3'b100;
    localparam rgb_t RGB_BG   = 3'b000;

    // Rows are left/right symmetric, so column bit order does not matter.
    function automatic logic [7:0] ball_rom(input logic [2:0] row);
        logic [7:0] bits;
        case (row)
            3'd0, 3'd7: bits = 8'b0011_1100;
            3'd1, 3'd6: bits = 8'b0111_1110;
            default:    bits = 8'b1111_1111;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/pong_arena_if.sv
// Pixel, button and overlay/event signals between the video pipeline and the pong engine.
interface pong_arena_if;

    logic [1:0] btn1;
    logic [1:0] btn2;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       graph_still;
    logic       graph_on;
    logic [2:0] graph_rgb;
    logic       hit;
    logic       miss;
    logic       miss_side;

    modport master (
        output btn1, btn2, pix_x, pix_y, graph_still,
        input  graph_on, graph_rgb, hit, miss, miss_side
    );

    modport slave (
        input  btn1, btn2, pix_x, pix_y, graph_still,
        output graph_on, graph_rgb, hit, miss, miss_side
    );

endinterface

// File: rtl/pong_arena_paddle.sv
// One paddle: clamped vertical position updated per frame, plus its pixel rectangle test.
module pong_arena_paddle #(
    parameter int unsigned X_L   = 32,
    parameter int unsigned BAR_W = 4,
    parameter int unsigned BAR_H = 72,
    parameter int unsigned STEP  = 4,
    parameter int unsigned MAX_Y = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic [1:0] i_btn,
    input  logic [9:0] i_pix_x,
    input  logic [9:0] i_pix_y,
    output logic [9:0] o_y,
    output logic       o_on
);

    localparam logic [9:0] XL     = 10'(X_L);
    localparam logic [9:0] XR     = 10'(X_L + BAR_W);
    localparam logic [9:0] H      = 10'(BAR_H);
    localparam logic [9:0] ST     = 10'(STEP);
    localparam logic [9:0] Y_MAX  = 10'(MAX_Y - BAR_H);
    localparam logic [9:0] Y_INIT = 10'((MAX_Y - BAR_H) / 2);

    logic [9:0] r_y;
    logic [9:0] w_y_next;

    // Compare before subtracting so the position never wraps below zero.
    always_comb begin
        w_y_next = r_y;
        case (i_btn)
            2'b01:   w_y_next = (r_y >= ST) ? r_y - ST : '0;
            2'b10:   w_y_next = (r_y + ST <= Y_MAX) ? r_y + ST : Y_MAX;
            default: w_y_next = r_y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_y <= Y_INIT;
        end else if (i_tick) begin
            r_y <= w_y_next;
        end
    end

    assign o_y  = r_y;
    assign o_on = (i_pix_x >= XL) && (i_pix_x < XR) && (i_pix_y >= r_y) && (i_pix_y < r_y + H);

endmodule

// File: rtl/pong_arena.sv
// Pong object engine: per-frame ball motion and paddle/wall collisions, registered RGB overlay.
module pong_arena
    import pong_arena_pkg::*;
#(
    parameter int unsigned MAX_X    = DEF_MAX_X,
    parameter int unsigned MAX_Y    = DEF_MAX_Y,
    parameter int unsigned BAR_H    = 72,
    parameter int unsigned BAR_W    = 4,
    parameter int unsigned BARL_X   = 32,
    parameter int unsigned BARR_X   = 600,
    parameter int unsigned BAR_STEP = 4,
    parameter int unsigned V_INIT   = 2,
    parameter int unsigned V_MAX    = 6
) (
    input logic         clk,
    input logic         reset,
    pong_arena_if.slave bus
);

    localparam logic [9:0] BS    = 10'(BALL_SIZE);
    localparam logic [9:0] LIM_X = 10'(MAX_X);
    localparam logic [9:0] LIM_Y = 10'(MAX_Y);
    localparam logic [9:0] CEN_X = 10'((MAX_X - BALL_SIZE) / 2);
    localparam logic [9:0] CEN_Y = 10'((MAX_Y - BALL_SIZE) / 2);
    localparam logic [9:0] BL_L  = 10'(BARL_X);
    localparam logic [9:0] BL_R  = 10'(BARL_X + BAR_W);
    localparam logic [9:0] BR_L  = 10'(BARR_X);
    localparam logic [9:0] BR_R  = 10'(BARR_X + BAR_W);
    localparam logic [9:0] BH    = 10'(BAR_H);
    localparam logic [9:0] VI    = 10'(V_INIT);
    localparam logic [9:0] VM    = 10'(V_MAX);

    logic [9:0] r_ball_x, r_ball_y, r_vx, r_vy, r_speed;
    logic       r_hit, r_miss, r_miss_side, r_graph_on;
    rgb_t       r_rgb;

    logic       w_tick;
    logic [9:0] w_barl_y, w_barr_y;
    logic       w_barl_on, w_barr_on;
    logic [9:0] w_bx_end, w_by_end, w_speed_up, w_speed_n, w_vx_n, w_vy_n, w_x_n, w_y_n;
    logic       w_vx_neg, w_vy_neg_n, w_top, w_bot;
    logic       w_hit_r, w_hit_l, w_hit, w_miss_r, w_miss_l, w_miss;
    logic       w_ball_sq, w_ball_on;
    logic [2:0] w_row, w_col;
    logic [7:0] w_rom;
    rgb_t       w_rgb;

    assign w_tick = (bus.pix_x == '0) && (bus.pix_y == LIM_Y);

    pong_arena_paddle #(
        .X_L(BARL_X), .BAR_W(BAR_W), .BAR_H(BAR_H), .STEP(BAR_STEP), .MAX_Y(MAX_Y)
    ) u_barl (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_btn(bus.btn1),
        .i_pix_x(bus.pix_x), .i_pix_y(bus.pix_y), .o_y(w_barl_y), .o_on(w_barl_on)
    );

    pong_arena_paddle #(
        .X_L(BARR_X), .BAR_W(BAR_W), .BAR_H(BAR_H), .STEP(BAR_STEP), .MAX_Y(MAX_Y)
    ) u_barr (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_btn(bus.btn2),
        .i_pix_x(bus.pix_x), .i_pix_y(bus.pix_y), .o_y(w_barr_y), .o_on(w_barr_on)
    );

    always_comb begin
        w_bx_end   = r_ball_x + BS;
        w_by_end   = r_ball_y + BS;
        w_vx_neg   = r_vx[9];
        w_speed_up = (r_speed < VM) ? r_speed + 10'd1 : VM;
        w_top      = r_ball_y <= r_speed;
        w_bot      = w_by_end >= LIM_Y - r_speed;
        w_hit_r    = !w_vx_neg && (w_bx_end >= BR_L) && (w_bx_end <= BR_R) &&
                     (w_by_end > w_barr_y) && (r_ball_y < w_barr_y + BH);
        w_hit_l    = w_vx_neg && (r_ball_x >= BL_L) && (r_ball_x <= BL_R) &&
                     (w_by_end > w_barl_y) && (r_ball_y < w_barl_y + BH);
        w_hit      = w_hit_r | w_hit_l;
        w_miss_r   = !w_hit && (w_bx_end >= LIM_X);
        w_miss_l   = !w_hit && !w_miss_r && w_vx_neg && (r_ball_x < r_speed);
        w_miss     = w_miss_r | w_miss_l;

        if (w_hit)       w_speed_n = w_speed_up;
        else if (w_miss) w_speed_n = VI;
        else             w_speed_n = r_speed;

        if (w_top)      w_vy_neg_n = 1'b0;
        else if (w_bot) w_vy_neg_n = 1'b1;
        else            w_vy_neg_n = r_vy[9];
        // |vx| and |vy| always track the speed register, so vy is rebuilt from its sign.
        w_vy_n = w_vy_neg_n ? -w_speed_n : w_speed_n;

        if (w_hit_r)       w_vx_n = -w_speed_up;
        else if (w_hit_l)  w_vx_n = w_speed_up;
        else if (w_miss_r) w_vx_n = -VI;
        else if (w_miss_l) w_vx_n = VI;
        else               w_vx_n = r_vx;

        w_x_n = w_miss ? CEN_X : r_ball_x + w_vx_n;
        w_y_n = w_miss ? CEN_Y : r_ball_y + w_vy_n;

        w_ball_sq = (bus.pix_x >= r_ball_x) && (bus.pix_x < w_bx_end) &&
                    (bus.pix_y >= r_ball_y) && (bus.pix_y < w_by_end);
        w_row     = bus.pix_y[2:0] - r_ball_y[2:0];
        w_col     = bus.pix_x[2:0] - r_ball_x[2:0];
        w_rom     = ball_rom(w_row);
        w_ball_on = w_ball_sq && w_rom[w_col];

        if (w_barr_on)      w_rgb = RGB_BARR;
        else if (w_barl_on) w_rgb = RGB_BARL;
        else if (w_ball_on) w_rgb = RGB_BALL;
        else                w_rgb = RGB_BG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ball_x    <= CEN_X;
            r_ball_y    <= CEN_Y;
            r_vx        <= VI;
            r_vy        <= VI;
            r_speed     <= VI;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_miss_side <= 1'b0;
            r_graph_on  <= 1'b0;
            r_rgb       <= RGB_BG;
        end else begin
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_graph_on <= w_barr_on | w_barl_on | w_ball_on;
            r_rgb      <= w_rgb;
            if (w_tick) begin
                if (bus.graph_still) begin
                    r_ball_x <= CEN_X;
                    r_ball_y <= CEN_Y;
                    r_vx     <= VI;
                    r_vy     <= VI;
                    r_speed  <= VI;
                end else begin
                    r_ball_x <= w_x_n;
                    r_ball_y <= w_y_n;
                    r_vx     <= w_vx_n;
                    r_vy     <= w_vy_n;
                    r_speed  <= w_speed_n;
                    r_hit    <= w_hit;
                    r_miss   <= w_miss;
                    if (w_miss) r_miss_side <= w_miss_r;
                end
            end
        end
    end

    assign bus.graph_on  = r_graph_on;
    assign bus.graph_rgb = r_rgb;
    assign bus.hit       = r_hit;
    assign bus.miss      = r_miss;
    assign bus.miss_side = r_miss_side;

endmodule
